// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg
//   Shared parameters and types for the operand fetch stage.
//   W_OPR  : default operand width
//   W_ADDR : default register address width (register 0 reads as zero)
//   state_e: fetch FSM states
package operand_fetch_pkg;

  localparam int W_OPR  = 32;
  localparam int W_ADDR = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } state_e;

endpackage

// File: rtl/operand_fetch_capture.sv
// operand_capture
//   Collects one source operand for the fetch stage. While enabled and not yet
//   captured it picks, in priority order: zero for register 0, the write-back
//   value when write-back targets this source, or the register file cell when
//   that cell is not write-reserved. Otherwise it keeps waiting.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   clear                start of a new instruction: drop flag and data
//   enable               the FSM is waiting for operands
//   src                  latched source register number
//   rf_data, rf_busy     register file cell contents and write-reserve bit
//   wb, wb_addr, wb_data write-back strobe, address and data
//   captured             operand already held in data
//   done                 operand held now or captured this cycle
//   data                 captured operand value
module operand_capture #(
  parameter int W_OPR  = operand_fetch_pkg::W_OPR,
  parameter int W_ADDR = operand_fetch_pkg::W_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [W_ADDR-1:0] src,
  input  logic [W_OPR-1:0]  rf_data,
  input  logic              rf_busy,
  input  logic              wb,
  input  logic [W_ADDR-1:0] wb_addr,
  input  logic [W_OPR-1:0]  wb_data,
  output logic              captured,
  output logic              done,
  output logic [W_OPR-1:0]  data
);

  logic             captured_reg;
  logic [W_OPR-1:0] data_reg;
  logic             take;
  logic [W_OPR-1:0] sel_data;
  logic             hit;

  // The zero test comes first so a write-back addressed to register 0 can
  // never leak into an operand.
  always_comb begin
    take     = 1'b0;
    sel_data = '0;
    if (src == '0) begin
      take     = 1'b1;
      sel_data = '0;
    end else if (wb && (wb_addr == src)) begin
      take     = 1'b1;
      sel_data = wb_data;
    end else if (!rf_busy) begin
      take     = 1'b1;
      sel_data = rf_data;
    end
  end

  assign hit = enable && !captured_reg && take;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      captured_reg <= 1'b0;
      data_reg     <= '0;
    end else if (clear) begin
      captured_reg <= 1'b0;
      data_reg     <= '0;
    end else if (hit) begin
      captured_reg <= 1'b1;
      data_reg     <= sel_data;
    end
  end

  assign captured = captured_reg;
  assign done     = captured_reg | hit;
  assign data     = data_reg;

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch
//   Accepts a decoded instruction, gathers both source operands from the
//   register file (with write-back bypass and write-reserve stalls), then
//   presents them to execute with a valid/ready handshake. On the execute
//   handshake it pulses reserve_o so the register file marks rd busy.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   id_valid_i / id_ready_o        decode handshake
//   id_rs1_i, id_rs2_i, id_rd_i    register numbers; id_rd_we_i writes rd
//   rs1_addr_o, rs2_addr_o         register file read addresses
//   rs1_data_i, rs2_data_i         register file read data
//   rs1_busy_i, rs2_busy_i         write-reserve bits of the addressed cells
//   wb_i, wb_addr_i, wb_data_i     write-back port
//   ex_valid_o / ex_ready_i        execute handshake
//   op_a_o, op_b_o, ex_rd_o, ex_rd_we_o  issued instruction
//   reserve_o, reserve_addr_o      write-reserve pulse and register
module operand_fetch #(
  parameter int W_OPR  = operand_fetch_pkg::W_OPR,
  parameter int W_ADDR = operand_fetch_pkg::W_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  output logic              id_ready_o,
  input  logic [W_ADDR-1:0] id_rs1_i,
  input  logic [W_ADDR-1:0] id_rs2_i,
  input  logic [W_ADDR-1:0] id_rd_i,
  input  logic              id_rd_we_i,
  output logic [W_ADDR-1:0] rs1_addr_o,
  output logic [W_ADDR-1:0] rs2_addr_o,
  input  logic [W_OPR-1:0]  rs1_data_i,
  input  logic [W_OPR-1:0]  rs2_data_i,
  input  logic              rs1_busy_i,
  input  logic              rs2_busy_i,
  input  logic              wb_i,
  input  logic [W_ADDR-1:0] wb_addr_i,
  input  logic [W_OPR-1:0]  wb_data_i,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [W_OPR-1:0]  op_a_o,
  output logic [W_OPR-1:0]  op_b_o,
  output logic [W_ADDR-1:0] ex_rd_o,
  output logic              ex_rd_we_o,
  output logic              reserve_o,
  output logic [W_ADDR-1:0] reserve_addr_o
);

  import operand_fetch_pkg::*;

  state_e            state_reg;
  state_e            state_next;
  logic [W_ADDR-1:0] rs1_reg;
  logic [W_ADDR-1:0] rs2_reg;
  logic [W_ADDR-1:0] rd_reg;
  logic              rd_we_reg;
  logic              accept;
  logic              ex_fire;
  logic              a_captured;
  logic              b_captured;
  logic              a_done;
  logic              b_done;
  logic              in_wait;

  // id_ready_o depends only on state and ex_ready_i, and ex_valid_o only on
  // state, so id_valid_i never reaches ex_valid_o combinationally.
  assign id_ready_o = (state_reg == IDLE) || ((state_reg == ISSUE) && ex_ready_i);
  assign accept     = id_valid_i && id_ready_o;
  assign ex_valid_o = (state_reg == ISSUE);
  assign ex_fire    = ex_valid_o && ex_ready_i;
  assign in_wait    = (state_reg == WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      rs1_reg   <= '0;
      rs2_reg   <= '0;
      rd_reg    <= '0;
      rd_we_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        rs1_reg   <= id_rs1_i;
        rs2_reg   <= id_rs2_i;
        rd_reg    <= id_rd_i;
        rd_we_reg <= id_rd_we_i;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = WAIT;
      end
      WAIT: begin
        // Operands captured this very cycle count, giving the 2-cycle minimum.
        if (a_done && b_done) state_next = ISSUE;
      end
      ISSUE: begin
        if (ex_fire) state_next = accept ? WAIT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  operand_capture #(.W_OPR(W_OPR), .W_ADDR(W_ADDR)) u_cap_a (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .enable   (in_wait),
    .src      (rs1_reg),
    .rf_data  (rs1_data_i),
    .rf_busy  (rs1_busy_i),
    .wb       (wb_i),
    .wb_addr  (wb_addr_i),
    .wb_data  (wb_data_i),
    .captured (a_captured),
    .done     (a_done),
    .data     (op_a_o)
  );

  operand_capture #(.W_OPR(W_OPR), .W_ADDR(W_ADDR)) u_cap_b (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .enable   (in_wait),
    .src      (rs2_reg),
    .rf_data  (rs2_data_i),
    .rf_busy  (rs2_busy_i),
    .wb       (wb_i),
    .wb_addr  (wb_addr_i),
    .wb_data  (wb_data_i),
    .captured (b_captured),
    .done     (b_done),
    .data     (op_b_o)
  );

  assign rs1_addr_o = rs1_reg;
  assign rs2_addr_o = rs2_reg;
  assign ex_rd_o    = rd_reg;
  assign ex_rd_we_o = rd_we_reg;

  // Combinational pulse: the register file sets the busy bit on the same edge
  // that completes the handshake, so a back-to-back reader sees it next cycle.
  assign reserve_o      = ex_fire && rd_we_reg && (rd_reg != '0);
  assign reserve_addr_o = rd_reg;

  // The captured flags only feed the done terms; keep them observable so the
  // capture state can be probed hierarchically when debugging.
  logic both_captured;
  assign both_captured = a_captured & b_captured;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  localparam int W_OPR  = 32;
  localparam int W_ADDR = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid_i;
  logic              id_ready_o;
  logic [W_ADDR-1:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic              id_rd_we_i;
  logic [W_ADDR-1:0] rs1_addr_o, rs2_addr_o;
  logic [W_OPR-1:0]  rs1_data_i, rs2_data_i;
  logic              rs1_busy_i, rs2_busy_i;
  logic              wb_i;
  logic [W_ADDR-1:0] wb_addr_i;
  logic [W_OPR-1:0]  wb_data_i;
  logic              ex_valid_o;
  logic              ex_ready_i;
  logic [W_OPR-1:0]  op_a_o, op_b_o;
  logic [W_ADDR-1:0] ex_rd_o;
  logic              ex_rd_we_o;
  logic              reserve_o;
  logic [W_ADDR-1:0] reserve_addr_o;

  int checks   = 0;
  int failures = 0;

  // Small register file environment: data, busy bits set by reserve_o or
  // by set_busy_en, cleared by write-back.
  logic [W_OPR-1:0]  rf_data [32] = '{default: '0};
  logic              rf_busy [32] = '{default: 1'b0};
  logic              set_busy_en;
  logic [W_ADDR-1:0] set_busy_addr;
  logic              force_busy1;

  assign rs1_data_i = rf_data[rs1_addr_o];
  assign rs2_data_i = rf_data[rs2_addr_o];
  assign rs1_busy_i = rf_busy[rs1_addr_o] | force_busy1;
  assign rs2_busy_i = rf_busy[rs2_addr_o];

  always @(posedge clk) begin
    if (wb_i && wb_addr_i != '0) begin
      rf_data[wb_addr_i] <= wb_data_i;
      rf_busy[wb_addr_i] <= 1'b0;
    end
    if (set_busy_en) rf_busy[set_busy_addr] <= 1'b1;
    if (reserve_o) rf_busy[reserve_addr_o] <= 1'b1;
  end

  always #5 clk = ~clk;

  operand_fetch #(.W_OPR(W_OPR), .W_ADDR(W_ADDR)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_rd_we_i(id_rd_we_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .rs1_busy_i(rs1_busy_i), .rs2_busy_i(rs2_busy_i),
    .wb_i(wb_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .ex_rd_o(ex_rd_o), .ex_rd_we_o(ex_rd_we_o),
    .reserve_o(reserve_o), .reserve_addr_o(reserve_addr_o)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we);
    id_valid_i = 1'b1;
    id_rs1_i   = rs1;
    id_rs2_i   = rs2;
    id_rd_i    = rd;
    id_rd_we_i = we;
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    wb_i = 1'b1; wb_addr_i = addr; wb_data_i = data;
    tick();
    wb_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (ex_valid_o !== 1'b0) begin failures++; $display("FAIL rst_ex_valid got=%0b exp=0", ex_valid_o); end
    checks++; if (reserve_o !== 1'b0) begin failures++; $display("FAIL rst_reserve got=%0b exp=0", reserve_o); end
    checks++; if (op_a_o !== 32'h0 || op_b_o !== 32'h0) begin failures++; $display("FAIL rst_ops got=%h/%h exp=0/0", op_a_o, op_b_o); end
    checks++; if (rs1_addr_o !== 5'd0 || ex_rd_o !== 5'd0 || ex_rd_we_o !== 1'b0) begin failures++; $display("FAIL rst_fields got=%0d/%0d/%0b exp=0/0/0", rs1_addr_o, ex_rd_o, ex_rd_we_o); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (id_ready_o !== 1'b1) begin failures++; $display("FAIL rst_id_ready got=%0b exp=1", id_ready_o); end
    // Preload register file contents.
    wb_write(5'd3, 32'h11);
    wb_write(5'd4, 32'h22);
    $display("txn reset done");
  endtask

  task automatic test_no_hazard();
    present(5'd3, 5'd4, 5'd8, 1'b1);
    #1;
    checks++; if (id_ready_o !== 1'b1) begin failures++; $display("FAIL nohaz_id_ready got=%0b exp=1", id_ready_o); end
    tick();
    id_valid_i = 1'b0;
    checks++; if (ex_valid_o !== 1'b0 || rs1_addr_o !== 5'd3 || rs2_addr_o !== 5'd4) begin failures++; $display("FAIL nohaz_wait got=%0b/%0d/%0d exp=0/3/4", ex_valid_o, rs1_addr_o, rs2_addr_o); end
    tick();
    checks++; if (ex_valid_o !== 1'b1) begin failures++; $display("FAIL nohaz_valid got=%0b exp=1", ex_valid_o); end
    checks++; if (op_a_o !== 32'h11 || op_b_o !== 32'h22) begin failures++; $display("FAIL nohaz_ops got=%h/%h exp=11/22", op_a_o, op_b_o); end
    checks++; if (ex_rd_o !== 5'd8 || ex_rd_we_o !== 1'b1 || id_ready_o !== 1'b0) begin failures++; $display("FAIL nohaz_rd got=%0d/%0b/%0b exp=8/1/0", ex_rd_o, ex_rd_we_o, id_ready_o); end
    ex_ready_i = 1'b1;
    #1;
    checks++; if (reserve_o !== 1'b1 || reserve_addr_o !== 5'd8 || id_ready_o !== 1'b1) begin failures++; $display("FAIL nohaz_reserve got=%0b/%0d/%0b exp=1/8/1", reserve_o, reserve_addr_o, id_ready_o); end
    tick();
    ex_ready_i = 1'b0;
    checks++; if (ex_valid_o !== 1'b0 || reserve_o !== 1'b0) begin failures++; $display("FAIL nohaz_idle got=%0b/%0b exp=0/0", ex_valid_o, reserve_o); end
    wb_write(5'd8, 32'h88);
    $display("txn no_hazard op_a=%h op_b=%h", 32'h11, 32'h22);
  endtask

  task automatic test_busy_stall();
    set_busy_en = 1'b1; set_busy_addr = 5'd5;
    tick();
    set_busy_en = 1'b0;
    present(5'd5, 5'd3, 5'd0, 1'b0);
    tick();
    id_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ex_valid_o !== 1'b0) begin failures++; $display("FAIL busy_stall_%0d got=%0b exp=0", i, ex_valid_o); end
      tick();
    end
    wb_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'hABCD;
    tick();
    wb_i = 1'b0;
    checks++; if (ex_valid_o !== 1'b1) begin failures++; $display("FAIL busy_valid got=%0b exp=1", ex_valid_o); end
    checks++; if (op_a_o !== 32'hABCD || op_b_o !== 32'h11) begin failures++; $display("FAIL busy_ops got=%h/%h exp=abcd/11", op_a_o, op_b_o); end
    ex_ready_i = 1'b1;
    #1;
    checks++; if (reserve_o !== 1'b0) begin failures++; $display("FAIL busy_no_reserve got=%0b exp=0", reserve_o); end
    tick();
    ex_ready_i = 1'b0;
    $display("txn busy_stall op_a=%h", 32'hABCD);
  endtask

  task automatic test_back_to_back();
    present(5'd3, 5'd4, 5'd7, 1'b1);
    tick();
    id_valid_i = 1'b0;
    tick();
    checks++; if (ex_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_i1_valid got=%0b exp=1", ex_valid_o); end
    present(5'd7, 5'd4, 5'd9, 1'b0);
    ex_ready_i = 1'b1;
    #1;
    checks++; if (reserve_o !== 1'b1 || reserve_addr_o !== 5'd7 || id_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_reserve got=%0b/%0d/%0b exp=1/7/1", reserve_o, reserve_addr_o, id_ready_o); end
    tick();
    id_valid_i = 1'b0;
    ex_ready_i = 1'b0;
    checks++; if (reserve_o !== 1'b0 || rs1_addr_o !== 5'd7) begin failures++; $display("FAIL b2b_pulse got=%0b/%0d exp=0/7", reserve_o, rs1_addr_o); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (ex_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_stall_%0d got=%0b exp=0", i, ex_valid_o); end
      tick();
    end
    wb_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'h777;
    tick();
    wb_i = 1'b0;
    checks++; if (ex_valid_o !== 1'b1 || op_a_o !== 32'h777 || op_b_o !== 32'h22) begin failures++; $display("FAIL b2b_i2 got=%0b/%h/%h exp=1/777/22", ex_valid_o, op_a_o, op_b_o); end
    checks++; if (ex_rd_o !== 5'd9 || ex_rd_we_o !== 1'b0) begin failures++; $display("FAIL b2b_i2_rd got=%0d/%0b exp=9/0", ex_rd_o, ex_rd_we_o); end
    ex_ready_i = 1'b1;
    tick();
    ex_ready_i = 1'b0;
    $display("txn back_to_back op_a=%h", 32'h777);
  endtask

  task automatic test_zero_reg();
    force_busy1 = 1'b1;
    present(5'd0, 5'd4, 5'd0, 1'b1);
    tick();
    id_valid_i = 1'b0;
    wb_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hDEAD;
    tick();
    wb_i = 1'b0;
    checks++; if (ex_valid_o !== 1'b1) begin failures++; $display("FAIL zero_no_stall got=%0b exp=1", ex_valid_o); end
    checks++; if (op_a_o !== 32'h0 || op_b_o !== 32'h22) begin failures++; $display("FAIL zero_ops got=%h/%h exp=0/22", op_a_o, op_b_o); end
    ex_ready_i = 1'b1;
    #1;
    checks++; if (reserve_o !== 1'b0) begin failures++; $display("FAIL zero_no_reserve got=%0b exp=0", reserve_o); end
    tick();
    ex_ready_i = 1'b0;
    force_busy1 = 1'b0;
    $display("txn zero_reg op_a=%h", 32'h0);
  endtask

  task automatic test_backpressure();
    present(5'd3, 5'd4, 5'd10, 1'b1);
    tick();
    present(5'd4, 5'd3, 5'd11, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      id_rs1_i = 5'(i + 12);
      #1;
      checks++; if (ex_valid_o !== 1'b1 || id_ready_o !== 1'b0) begin failures++; $display("FAIL bp_hs_%0d got=%0b/%0b exp=1/0", i, ex_valid_o, id_ready_o); end
      checks++; if (op_a_o !== 32'h11 || op_b_o !== 32'h22 || ex_rd_o !== 5'd10 || ex_rd_we_o !== 1'b1) begin failures++; $display("FAIL bp_stable_%0d got=%h/%h/%0d/%0b exp=11/22/10/1", i, op_a_o, op_b_o, ex_rd_o, ex_rd_we_o); end
      tick();
    end
    id_valid_i = 1'b0;
    ex_ready_i = 1'b1;
    #1;
    checks++; if (reserve_o !== 1'b1 || reserve_addr_o !== 5'd10) begin failures++; $display("FAIL bp_reserve got=%0b/%0d exp=1/10", reserve_o, reserve_addr_o); end
    tick();
    ex_ready_i = 1'b0;
    $display("txn backpressure rd=%0d", 10);
  endtask

  task automatic test_reset_mid();
    // Register 10 is reserved from the previous test, so this stalls in WAIT.
    present(5'd10, 5'd3, 5'd12, 1'b1);
    tick();
    id_valid_i = 1'b0;
    tick();
    checks++; if (ex_valid_o !== 1'b0) begin failures++; $display("FAIL rstw_stall got=%0b exp=0", ex_valid_o); end
    rst = 1'b0;
    #1;
    checks++; if (ex_valid_o !== 1'b0 || rs1_addr_o !== 5'd0 || op_b_o !== 32'h0) begin failures++; $display("FAIL rstw_clear got=%0b/%0d/%h exp=0/0/0", ex_valid_o, rs1_addr_o, op_b_o); end
    tick();
    rst = 1'b1;
    #1;
    checks++; if (id_ready_o !== 1'b1 || ex_valid_o !== 1'b0) begin failures++; $display("FAIL rstw_release got=%0b/%0b exp=1/0", id_ready_o, ex_valid_o); end
    // Reset while in ISSUE with execute ready: no reserve pulse.
    present(5'd3, 5'd4, 5'd13, 1'b1);
    tick();
    id_valid_i = 1'b0;
    tick();
    checks++; if (ex_valid_o !== 1'b1) begin failures++; $display("FAIL rsti_valid got=%0b exp=1", ex_valid_o); end
    rst = 1'b0;
    ex_ready_i = 1'b1;
    #1;
    checks++; if (reserve_o !== 1'b0 || ex_valid_o !== 1'b0) begin failures++; $display("FAIL rsti_no_reserve got=%0b/%0b exp=0/0", reserve_o, ex_valid_o); end
    tick();
    ex_ready_i = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if (id_ready_o !== 1'b1 || ex_valid_o !== 1'b0) begin failures++; $display("FAIL rsti_release got=%0b/%0b exp=1/0", id_ready_o, ex_valid_o); end
    $display("txn reset_mid done");
  endtask

  initial begin
    rst = 1'b0;
    id_valid_i = 1'b0; id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0; id_rd_we_i = 1'b0;
    wb_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    ex_ready_i = 1'b0;
    set_busy_en = 1'b0; set_busy_addr = '0; force_busy1 = 1'b0;
    test_reset();
    test_no_hazard();
    test_busy_stall();
    test_back_to_back();
    test_zero_reg();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
